// File: rtl/lut_gate_if.sv
// Purpose: bundles the configuration, upstream and downstream handshake
//          signals of lut_gate_pipe.
// Ports (signals):
//   cfg_we, cfg_tt          truth-table write strobe and value
//   up_valid/up_ready       operand handshake, with up_a / up_b
//   down_valid/down_ready   result handshake, with down_o
//   done_cnt                results consumed since reset (wraps)
// Modports: master drives operands/config and consumes results;
//           slave is the gate pipeline itself.
interface lut_gate_if #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned COUNT_W = 8
);
    logic               cfg_we;
    logic [3:0]         cfg_tt;
    logic               up_valid;
    logic               up_ready;
    logic [WIDTH-1:0]   up_a;
    logic [WIDTH-1:0]   up_b;
    logic               down_valid;
    logic               down_ready;
    logic [WIDTH-1:0]   down_o;
    logic [COUNT_W-1:0] done_cnt;

    modport master (
        output cfg_we, cfg_tt, up_valid, up_a, up_b, down_ready,
        input  up_ready, down_valid, down_o, done_cnt
    );

    modport slave (
        input  cfg_we, cfg_tt, up_valid, up_a, up_b, down_ready,
        output up_ready, down_valid, down_o, done_cnt
    );
endinterface

// File: rtl/lut_gate_pipe.sv
// Purpose: programmable 2-input bitwise gate (any of the 16 functions)
//          built from 2:1 mux instances, in a 2-stage valid/ready pipe.
//          Result bit i = tt[{a[i], b[i]}].
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous reset, active-high
//   bus   lut_gate_if.slave: cfg_we/cfg_tt, up_valid/up_ready/up_a/up_b,
//         down_valid/down_ready/down_o, done_cnt

// Single 2:1 mux primitive; the only logic element in the gate tree.
module lut_gate_mux2 (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic y
);
    assign y = sel ? d1 : d0;
endmodule

module lut_gate_pipe #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned COUNT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    lut_gate_if.slave   bus
);
    localparam logic [3:0] TT_AND = 4'b1000;

    // Live truth table; snapshotted per transaction at accept.
    logic [3:0]         tt_q;

    // Stage 1: operands plus the truth table in force when accepted.
    logic               s1_valid;
    logic [WIDTH-1:0]   s1_a;
    logic [WIDTH-1:0]   s1_b;
    logic [3:0]         s1_tt;

    // Stage 2: evaluated result.
    logic               s2_valid;
    logic [WIDTH-1:0]   s2_o;

    logic [COUNT_W-1:0] cnt_q;

    logic               s2_ready_c;
    logic               up_ready_c;
    logic               accept_c;
    logic               pop_c;
    logic [WIDTH-1:0]   lo_c;
    logic [WIDTH-1:0]   hi_c;
    logic [WIDTH-1:0]   res_c;

    // Ready chain: a stage can take data when empty or when it drains.
    assign s2_ready_c = !s2_valid || bus.down_ready;
    assign up_ready_c = !s1_valid || s2_ready_c;
    assign accept_c   = bus.up_valid && up_ready_c;
    assign pop_c      = s2_valid && bus.down_ready;

    // Per-bit 4:1 mux tree: b picks within each half, a picks the half.
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        lut_gate_mux2 u_lo (
            .d0  (s1_tt[0]),
            .d1  (s1_tt[1]),
            .sel (s1_b[i]),
            .y   (lo_c[i])
        );
        lut_gate_mux2 u_hi (
            .d0  (s1_tt[2]),
            .d1  (s1_tt[3]),
            .sel (s1_b[i]),
            .y   (hi_c[i])
        );
        lut_gate_mux2 u_top (
            .d0  (lo_c[i]),
            .d1  (hi_c[i]),
            .sel (s1_a[i]),
            .y   (res_c[i])
        );
    end

    // Truth-table register; an accept in the same cycle sees the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tt_q <= TT_AND;
        end else if (bus.cfg_we) begin
            tt_q <= bus.cfg_tt;
        end
    end

    // Stage 1: valid follows up_valid whenever the stage may move;
    // data loads only on a real accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_tt    <= TT_AND;
        end else begin
            if (up_ready_c) begin
                s1_valid <= bus.up_valid;
            end
            if (accept_c) begin
                s1_a  <= bus.up_a;
                s1_b  <= bus.up_b;
                s1_tt <= tt_q;
            end
        end
    end

    // Stage 2: result holds while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_o     <= '0;
        end else if (s2_ready_c) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_o <= res_c;
            end
        end
    end

    // Consumed-result counter, wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (pop_c) begin
            cnt_q <= cnt_q + COUNT_W'(1);
        end
    end

    assign bus.up_ready   = up_ready_c;
    assign bus.down_valid = s2_valid;
    assign bus.down_o     = s2_o;
    assign bus.done_cnt   = cnt_q;
endmodule
